// File: rtl/m_store_buffer.sv
// rtl/m_store_buffer.sv - M-stage store buffer with lane formatting, load hazard check and optional coalescing
//
// Purpose: queues pipeline stores, formats them into word-aligned lane writes,
// drains them to data memory in FIFO order, and flags loads that overlap a
// pending store word.
//
// Optional feature macro: SB_COALESCE_EN. When defined, a store to the same word as
// the tail entry is merged into it, provided the tail is not the head.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   st_valid/st_ready   store request handshake from the M stage
//   BEOp, Addr, rt_data store width (00 none, 01 word, 10 half, 11 byte), byte address, data
//   ld_valid, ld_addr   load hazard probe; ld_stall is the combinational result
//   m_data_*            head entry presented to data memory (valid/ready handshake)
//   st_misalign         one-cycle pulse after a rejected misaligned store
//   sb_count            current occupancy
module m_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [1:0]                 BEOp,
    input  logic [31:0]                Addr,
    input  logic [31:0]                rt_data,
    input  logic                       ld_valid,
    input  logic [31:0]                ld_addr,
    output logic                       ld_stall,
    output logic                       m_data_valid,
    input  logic                       m_data_ready,
    output logic [31:0]                m_data_addr,
    output logic [3:0]                 m_data_byteen,
    output logic [31:0]                m_data_wdata,
    output logic                       st_misalign,
    output logic [$clog2(DEPTH):0]     sb_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [29:0]   ent_waddr  [DEPTH];
    logic [3:0]    ent_byteen [DEPTH];
    logic [31:0]   ent_wdata  [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          misalign_q;

    logic          is_word;
    logic          is_half;
    logic          misaligned;
    logic          st_req;
    logic          push;
    logic          pop;
    logic          merge;
    logic          alloc;
    logic [PW-1:0] tail_ptr;
    logic [3:0]    new_byteen;
    logic [31:0]   new_wdata;
    logic [31:0]   new_mask;
    logic          hit;
    logic          unused_ld_low;

    assign unused_ld_low = ^ld_addr[1:0];

    assign is_word    = (BEOp == 2'b01);
    assign is_half    = (BEOp == 2'b10);
    assign misaligned = (is_word && (Addr[1:0] != 2'b00)) || (is_half && Addr[0]);
    assign st_req     = st_valid && st_ready && (BEOp != 2'b00);
    assign push       = st_req && !misaligned;

    assign st_ready     = (count < CW'(DEPTH));
    assign m_data_valid = (count != '0);
    assign pop          = m_data_valid && m_data_ready;
    assign tail_ptr     = wr_ptr - 1'b1;

    // The count>=2 condition keeps the tail distinct from the head, so the
    // entry currently presented to memory is never modified.
`ifdef SB_COALESCE_EN
    assign merge = push && (count >= CW'(2)) && (ent_waddr[tail_ptr] == Addr[31:2]);
`else
    assign merge = 1'b0;
`endif
    assign alloc = push && !merge;

    // Lane formatting: data lands in the byte lanes selected by the address,
    // unselected lanes are zero.
    always_comb begin
        new_byteen = 4'b0000;
        new_wdata  = 32'h0;
        case (BEOp)
            2'b01: begin
                new_byteen = 4'b1111;
                new_wdata  = rt_data;
            end
            2'b10: begin
                if (Addr[1]) begin
                    new_byteen = 4'b1100;
                    new_wdata  = {rt_data[15:0], 16'h0};
                end else begin
                    new_byteen = 4'b0011;
                    new_wdata  = {16'h0, rt_data[15:0]};
                end
            end
            2'b11: begin
                new_byteen = 4'b0001 << Addr[1:0];
                new_wdata  = {24'h0, rt_data[7:0]} << {Addr[1:0], 3'b000};
            end
            default: begin
                new_byteen = 4'b0000;
                new_wdata  = 32'h0;
            end
        endcase
    end

    assign new_mask = {{8{new_byteen[3]}}, {8{new_byteen[2]}},
                       {8{new_byteen[1]}}, {8{new_byteen[0]}}};

    // An entry is occupied when its distance from the head is below the count;
    // the head counts even while it is being popped this cycle.
    always_comb begin
        logic [PW-1:0] off;
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if ((CW'(off) < count) && (ent_waddr[i] == ld_addr[31:2])) begin
                hit = 1'b1;
            end
        end
    end

    assign ld_stall = ld_valid && hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_waddr[i]  <= '0;
                ent_byteen[i] <= '0;
                ent_wdata[i]  <= '0;
            end
        end else begin
            misalign_q <= st_req && misaligned;
            if (alloc) begin
                ent_waddr[wr_ptr]  <= Addr[31:2];
                ent_byteen[wr_ptr] <= new_byteen;
                ent_wdata[wr_ptr]  <= new_wdata;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (merge) begin
                ent_byteen[tail_ptr] <= ent_byteen[tail_ptr] | new_byteen;
                ent_wdata[tail_ptr]  <= (ent_wdata[tail_ptr] & ~new_mask) | new_wdata;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({alloc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign m_data_addr   = {ent_waddr[rd_ptr], 2'b00};
    assign m_data_byteen = ent_byteen[rd_ptr];
    assign m_data_wdata  = ent_wdata[rd_ptr];
    assign st_misalign   = misalign_q;
    assign sb_count      = count;

endmodule

// File: tb/tb_m_store_buffer.sv
// tb/tb_m_store_buffer.sv - directed self-checking bench for m_store_buffer
module tb_m_store_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  BEOp;
    logic [31:0] Addr;
    logic [31:0] rt_data;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        m_data_valid;
    logic        m_data_ready;
    logic [31:0] m_data_addr;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_wdata;
    logic        st_misalign;
    logic [2:0]  sb_count;

    int checks = 0;
    int failures = 0;

    m_store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .st_valid(st_valid), .st_ready(st_ready),
        .BEOp(BEOp), .Addr(Addr), .rt_data(rt_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
        .m_data_addr(m_data_addr), .m_data_byteen(m_data_byteen),
        .m_data_wdata(m_data_wdata), .st_misalign(st_misalign),
        .sb_count(sb_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        BEOp     = op;
        Addr     = a;
        rt_data  = d;
        @(posedge clk); #1;
        st_valid = 1'b0;
        BEOp     = 2'b00;
    endtask

    task automatic drain();
        m_data_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        m_data_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; st_valid = 1'b0; BEOp = 2'b00; Addr = '0; rt_data = '0;
        ld_valid = 1'b0; ld_addr = '0; m_data_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_count", 32'(sb_count), 0);
        chk("rst_valid", 32'(m_data_valid), 0);
        chk("rst_ready", 32'(st_ready), 1);
        chk("rst_misalign", 32'(st_misalign), 0);

        // Byte store to lane 3, popped the cycle it appears
        @(posedge clk); #1;
        m_data_ready = 1'b1;
        st_valid = 1'b1; BEOp = 2'b11; Addr = 32'h1003; rt_data = 32'hAB;
        @(negedge clk);
        chk("sb_not_yet", 32'(m_data_valid), 0);
        @(posedge clk); #1;
        st_valid = 1'b0; BEOp = 2'b00;
        @(negedge clk);
        chk("sb_valid", 32'(m_data_valid), 1);
        chk("sb_addr", m_data_addr, 32'h1000);
        chk("sb_byteen", 32'(m_data_byteen), 32'b1000);
        chk("sb_wdata", m_data_wdata, 32'hAB000000);
        @(negedge clk);
        chk("sb_popped", 32'(sb_count), 0);

        // Fill to full with memory stalled, then drain in order
        @(posedge clk); #1;
        m_data_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(2'b01, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        @(negedge clk);
        chk("full_count", 32'(sb_count), 4);
        chk("full_ready", 32'(st_ready), 0);
        @(posedge clk); #1;
        st_valid = 1'b1; BEOp = 2'b01; Addr = 32'h110; rt_data = 32'hA4;
        @(posedge clk); #1;
        st_valid = 1'b0; BEOp = 2'b00;
        @(negedge clk);
        chk("fifth_held_count", 32'(sb_count), 4);
        chk("head_stable_addr", m_data_addr, 32'h100);
        chk("head_stable_data", m_data_wdata, 32'hA0);
        @(posedge clk); #1;
        m_data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("drain_addr%0d", i), m_data_addr, 32'h100 + 32'(4 * i));
            chk($sformatf("drain_data%0d", i), m_data_wdata, 32'hA0 + 32'(i));
        end
        @(negedge clk);
        chk("drained", 32'(sb_count), 0);

        // Load hazard against a pending word
        @(posedge clk); #1;
        m_data_ready = 1'b0;
        push(2'b01, 32'h2000, 32'h1);
        ld_valid = 1'b1; ld_addr = 32'h2002;
        #1 chk("ld_hit", 32'(ld_stall), 1);
        ld_addr = 32'h2004;
        #1 chk("ld_other_word", 32'(ld_stall), 0);
        ld_addr = 32'h2002; ld_valid = 1'b0;
        #1 chk("ld_not_valid", 32'(ld_stall), 0);
        ld_valid = 1'b1; m_data_ready = 1'b1;
        #1 chk("ld_hit_popping", 32'(ld_stall), 1);
        @(posedge clk); #1;
        m_data_ready = 1'b0;
        chk("ld_after_drain", 32'(ld_stall), 0);
        ld_valid = 1'b0;

        // Misaligned half store
        push(2'b10, 32'h3001, 32'h55);
        @(negedge clk);
        chk("mis_pulse", 32'(st_misalign), 1);
        chk("mis_count", 32'(sb_count), 0);
        @(negedge clk);
        chk("mis_clear", 32'(st_misalign), 0);

        // Half lanes
        @(posedge clk); #1;
        push(2'b10, 32'h3002, 32'h1234BEEF);
        push(2'b10, 32'h3004, 32'h1234BEEF);
        @(negedge clk);
        chk("sh_hi_byteen", 32'(m_data_byteen), 32'b1100);
        chk("sh_hi_wdata", m_data_wdata, 32'hBEEF0000);
        @(posedge clk); #1;
        m_data_ready = 1'b1;
        @(posedge clk); #1;
        m_data_ready = 1'b0;
        chk("sh_lo_addr", m_data_addr, 32'h3004);
        chk("sh_lo_byteen", 32'(m_data_byteen), 32'b0011);
        chk("sh_lo_wdata", m_data_wdata, 32'h0000BEEF);
        drain();

        // Coalescing into the tail entry
        push(2'b01, 32'h10, 32'hDEADBEEF);
        push(2'b11, 32'h20, 32'h11);
        push(2'b11, 32'h21, 32'h22);
        @(negedge clk);
`ifdef SB_COALESCE_EN
        chk("coal_count", 32'(sb_count), 2);
`else
        chk("coal_count", 32'(sb_count), 3);
`endif
        @(posedge clk); #1;
        m_data_ready = 1'b1;
        @(posedge clk); #1;
        m_data_ready = 1'b0;
        chk("coal_e2_addr", m_data_addr, 32'h20);
`ifdef SB_COALESCE_EN
        chk("coal_e2_byteen", 32'(m_data_byteen), 32'b0011);
        chk("coal_e2_wdata", m_data_wdata, 32'h00002211);
`else
        chk("coal_e2_byteen", 32'(m_data_byteen), 32'b0001);
        chk("coal_e2_wdata", m_data_wdata, 32'h00000011);
`endif
        drain();

        // Asynchronous reset with entries pending
        push(2'b01, 32'h50, 32'h5);
        push(2'b01, 32'h60, 32'h6);
        push(2'b01, 32'h70, 32'h7);
        @(negedge clk);
        chk("pre_rst_count", 32'(sb_count), 3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(m_data_valid), 0);
        chk("async_rst_count", 32'(sb_count), 0);
        chk("async_rst_addr", m_data_addr, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        push(2'b01, 32'h80, 32'h8);
        @(negedge clk);
        chk("resume_count", 32'(sb_count), 1);
        chk("resume_addr", m_data_addr, 32'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/m_store_buffer.md
M_STORE_BUFFER -- requirements
Module: m_store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of buffer entries; legal values are powers of two, 2..8.
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 st_valid  in  1  store request from the pipeline M stage.
REQ-005 st_ready  out  1  buffer can accept a store this cycle.
REQ-006 BEOp  in  2  store width: 00 none, 01 word, 10 half, 11 byte.
REQ-007 Addr  in  32  store byte address.
REQ-008 rt_data  in  32  store source data (low-aligned).
REQ-009 ld_valid  in  1  a load in M needs a hazard check this cycle.
REQ-010 ld_addr  in  32  load byte address.
REQ-011 ld_stall  out  1  load overlaps a pending store word.
REQ-012 m_data_valid  out  1  head entry presented to data memory.
REQ-013 m_data_ready  in  1  memory accepts the head entry.
REQ-014 m_data_addr  out  32  word-aligned write address.
REQ-015 m_data_byteen  out  4  lane write enables.
REQ-016 m_data_wdata  out  32  lane-positioned write data.
REQ-017 st_misalign  out  1  one-cycle pulse flagging a rejected misaligned store.
REQ-018 sb_count  out  log2(DEPTH)+1  current occupancy.

Function
REQ-019 Enqueue SHALL occur when st_valid && st_ready && BEOp!=00 && the store is aligned; BEOp=00 SHALL be ignored.
REQ-020 Lane rule: word -> byteen 1111, data unchanged; half -> Addr[1]=0 gives 0011 with data {16'b0,rt_data[15:0]}, Addr[1]=1 gives 1100 with data {rt_data[15:0],16'b0}; byte -> one-hot byteen at bit Addr[1:0], rt_data[7:0] placed in byte lane Addr[1:0], all other lanes zero.
REQ-021 Misaligned means word with Addr[1:0]!=00 or half with Addr[0]=1; such a store SHALL NOT be enqueued, and st_misalign SHALL be 1 for exactly the following cycle.
REQ-022 st_ready SHALL be 1 iff sb_count<DEPTH; there is no same-cycle bypass when full, even while popping.
REQ-023 m_data_valid SHALL be 1 iff sb_count>0, with m_data_addr={head word addr,2'b00} and byteen/wdata taken from registered head state.
REQ-024 Head SHALL pop on m_data_valid && m_data_ready; head outputs SHALL remain stable while valid && !ready.
REQ-025 Latency: an accepted store SHALL appear at the head no earlier than the next cycle; entries SHALL drain in FIFO order.
REQ-026 A simultaneous push and pop SHALL leave sb_count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-027 ld_stall SHALL be combinational and equal ld_valid && (any occupied entry word address == ld_addr[31:2]), including the head being popped this cycle.

Reset
REQ-028 While reset_n=0, pointers, sb_count, st_misalign, m_data_valid and all entry fields SHALL be 0 immediately, without waiting for a clock edge.
REQ-029 Reset mid-transfer SHALL discard all pending entries; operation SHALL resume on the first rising clk edge after reset_n=1.

Configuration
REQ-030 With SB_COALESCE_EN defined, an enqueue whose word address equals the tail entry, when sb_count>=2, SHALL merge into that entry: byteen is ORed, new lanes overwrite old data, and sb_count is unchanged.
REQ-031 The head entry SHALL never be merged into.
REQ-032 Without SB_COALESCE_EN, every accepted store SHALL allocate a new entry.

Verification
REQ-033 After reset, ready=1, apply sb Addr=0x1003 rt_data=0xAB -> next cycle valid=1, addr=0x1000, byteen=1000, wdata=0xAB000000; popped that cycle.
REQ-034 ready=0, apply five sw stores -> sb_count=4, st_ready=0, fifth store held and head stable; then ready=1 -> four writes in order on consecutive cycles.
REQ-035 Pending sw at 0x2000, ld_valid=1, ld_addr=0x2002 -> ld_stall=1; after the entry drains -> ld_stall=0.
REQ-036 Apply sh Addr=0x3001 -> no enqueue, st_misalign pulses for one cycle, sb_count unchanged.
REQ-037 ready=0, apply sw 0x10, sb 0x20 data 0x11, sb 0x21 data 0x22 -> with SB_COALESCE_EN: sb_count=2 and the second entry has byteen=0011, wdata=0x00002211; without it: sb_count=3.
REQ-038 Drive reset_n=0 while sb_count=3 and valid=1 -> m_data_valid=0 and sb_count=0 with no clock edge.
